// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared defaults, drain FSM states and width helpers
package systolic_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;
    localparam int DEF_TILES  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // Index width for n distinct values, never below one bit
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must reach n inclusive
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tile_ram.sv
// rtl/tile_ram.sv - flop array of tile slots, whole-tile write, element read
module tile_ram
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NE     = DEF_ROWS * DEF_COLS,
    parameter int TILES  = DEF_TILES,
    localparam int IW    = idx_w(NE),
    localparam int PW    = idx_w(TILES)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PW-1:0]        wr_slot,
    input  logic [NE*DATA_W-1:0] wr_tile,
    input  logic [PW-1:0]        rd_slot,
    input  logic [IW-1:0]        rd_k,
    output logic [DATA_W-1:0]    rd_data
);

    logic [NE*DATA_W-1:0] mem [TILES];

    // Whole tile lands in its slot on one edge; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_slot] <= wr_tile;
        end
    end

    // Combinational single-element read of (slot, k)
    always_comb begin
        rd_data = mem[rd_slot][rd_k*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/output_tile_buffer.sv
// rtl/output_tile_buffer.sv - multi-tile FIFO ring draining one element per handshake
module output_tile_buffer
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int TILES  = DEF_TILES,
    localparam int NE    = ROWS * COLS,
    localparam int IW    = idx_w(NE),
    localparam int CW    = cnt_w(TILES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [NE*DATA_W-1:0] wr_data,
    input  logic                 col_major,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [IW-1:0]        out_idx,
    output logic                 out_last,
    output logic [CW-1:0]        tile_count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    input  logic                 clr_err
);

    localparam int PW  = idx_w(TILES);
    localparam int RW  = idx_w(ROWS);
    localparam int CLW = idx_w(COLS);

    drain_state_t      state, state_nxt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              ord;
    logic [IW-1:0]     seq_i, seq_nxt;
    logic [RW-1:0]     row, row_nxt;
    logic [CLW-1:0]    col, col_nxt;
    logic [IW-1:0]     k_nxt;
    logic [DATA_W-1:0] rd_data;
    logic              wr_fire, load_first, advance, release_tile;

    assign full       = (count == CW'(TILES));
    assign empty      = (count == '0);
    assign wr_ready   = !full;
    assign tile_count = count;
    assign wr_fire    = wr_valid && !full;

    tile_ram #(
        .DATA_W (DATA_W),
        .NE     (NE),
        .TILES  (TILES)
    ) u_tile_ram (
        .clk     (clk),
        .we      (wr_fire),
        .wr_slot (wr_ptr),
        .wr_tile (wr_data),
        .rd_slot (rd_ptr),
        .rd_k    (k_nxt),
        .rd_data (rd_data)
    );

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start a tile when one is held, return to IDLE after its last element
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = STREAM;
            STREAM:  if (out_ready && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: valid flag and the load/advance/release strobes
    always_comb begin
        out_valid    = (state == STREAM);
        load_first   = (state == IDLE) && !empty;
        advance      = (state == STREAM) && out_ready && !out_last;
        release_tile = (state == STREAM) && out_ready && out_last;
    end

    // Next (row, col) in the latched drain order; a fresh tile restarts at (0, 0)
    always_comb begin
        row_nxt = row;
        col_nxt = col;
        if (ord) begin
            if (row == RW'(ROWS - 1)) begin
                row_nxt = '0;
                col_nxt = col + 1'b1;
            end else begin
                row_nxt = row + 1'b1;
            end
        end else begin
            if (col == CLW'(COLS - 1)) begin
                col_nxt = '0;
                row_nxt = row + 1'b1;
            end else begin
                col_nxt = col + 1'b1;
            end
        end
        if (load_first) begin
            row_nxt = '0;
            col_nxt = '0;
        end
        seq_nxt = load_first ? '0 : seq_i + 1'b1;
        k_nxt   = IW'(int'(row_nxt) * COLS + int'(col_nxt));
    end

    // Output element register; held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            seq_i    <= '0;
            row      <= '0;
            col      <= '0;
            ord      <= 1'b0;
        end else if (load_first || advance) begin
            out_data <= rd_data;
            out_idx  <= k_nxt;
            out_last <= (seq_nxt == IW'(NE - 1));
            seq_i    <= seq_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            if (load_first) begin
                ord <= col_major;
            end
        end else if (release_tile) begin
            out_last <= 1'b0;
        end
    end

    // Ring pointers and occupancy; a write and a release on one edge cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= (wr_ptr == PW'(TILES - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (release_tile) begin
                rd_ptr <= (rd_ptr == PW'(TILES - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_fire, release_tile})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new drop beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_valid && full) begin
            overflow <= 1'b1;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end
    end

endmodule
